// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Iterative RV32M multiply/divide unit in the EX stage. An accepted op runs
//   one bit per cycle (shift-add multiply or restoring divide) over unsigned
//   magnitudes. The sign is corrected when the result is registered.
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   Flush_E             abort the op in flight (branch/jump flush)
//   Start_E             valid M-extension instruction present in EX
//   MulDivOp_E          RV32M funct3
//   SrcA_E, SrcB_E      forwarded rs1/rs2 operands
//   rd_E                destination register
//   Busy_E              combinational stall request to the hazard unit
//   ResultValid_E       one-cycle result strobe (registered)
//   Result_E, rdOut_E   registered result and destination register
module ex_muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int OP_WIDTH       = 3,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Flush_E,
  input  logic                      Start_E,
  input  logic [OP_WIDTH-1:0]       MulDivOp_E,
  input  logic [XLEN-1:0]           SrcA_E,
  input  logic [XLEN-1:0]           SrcB_E,
  input  logic [REG_ADDR_WIDTH-1:0] rd_E,
  output logic                      Busy_E,
  output logic                      ResultValid_E,
  output logic [XLEN-1:0]           Result_E,
  output logic [REG_ADDR_WIDTH-1:0] rdOut_E
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state, state_nxt;
  logic [OP_WIDTH-1:0]   op;
  logic                  neg;      // result must be negated in DONE
  logic [XLEN-1:0]       mcand;    // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]     acc;      // MUL: {partial hi, multiplier}; DIV: {remainder, quotient}
  logic [CNT_WIDTH-1:0]  cnt;

  logic                  accept, is_div, a_signed, b_signed, sign_a, sign_b;
  logic                  neg_in, div_zero, div_ovf, special;
  logic [XLEN-1:0]       mag_a, mag_b, forced;
  logic [XLEN:0]         mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0]     step_nxt;
  logic                  last_step;

  function automatic logic [XLEN-1:0] neg_word(input logic n, input logic [XLEN-1:0] v);
    return n ? (~v + 1'b1) : v;
  endfunction

  // Sign correction and half selection for the finished product/quotient/remainder.
  function automatic logic [XLEN-1:0] final_result(input logic [OP_WIDTH-1:0] f,
                                                   input logic n,
                                                   input logic [2*XLEN-1:0] p);
    logic [2*XLEN-1:0] pc;
    if (!f[2]) begin
      pc = n ? (~p + 1'b1) : p;
      return (f[1:0] == 2'b00) ? pc[XLEN-1:0] : pc[2*XLEN-1:XLEN];
    end
    return neg_word(n, f[1] ? p[2*XLEN-1:XLEN] : p[XLEN-1:0]);
  endfunction

  // Operand decode at accept
  always_comb begin
    is_div   = MulDivOp_E[2];
    // MUL/MULH/MULHSU treat A as signed; MUL/MULH treat B as signed; DIV/REM both.
    a_signed = is_div ? ~MulDivOp_E[0] : (MulDivOp_E[1:0] != 2'b11);
    b_signed = is_div ? ~MulDivOp_E[0] : ~MulDivOp_E[1];
    sign_a   = a_signed & SrcA_E[XLEN-1];
    sign_b   = b_signed & SrcB_E[XLEN-1];
    mag_a    = neg_word(sign_a, SrcA_E);
    mag_b    = neg_word(sign_b, SrcB_E);
    // Remainder takes the dividend sign; everything else takes sign(A)^sign(B).
    neg_in   = (is_div && MulDivOp_E[1]) ? sign_a : (sign_a ^ sign_b);
    div_zero = is_div && (SrcB_E == '0);
    div_ovf  = is_div && !MulDivOp_E[0] && (SrcA_E == {1'b1, {(XLEN-1){1'b0}}}) &&
               (SrcB_E == '1);
    special  = div_zero | div_ovf;
    forced   = '0;
    if (div_zero)
      forced = MulDivOp_E[1] ? SrcA_E : '1;
    else if (div_ovf)
      forced = MulDivOp_E[1] ? '0 : SrcA_E;
  end

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mcand : {XLEN{1'b0}})};
    div_shift = acc[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, mcand};
    if (op[2])
      step_nxt = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                : {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};
    else
      step_nxt = {mul_sum, acc[XLEN-1:1]};
    last_step = (cnt == CNT_WIDTH'(XLEN-1));
  end

  assign accept = (state == IDLE) && Start_E && !Flush_E;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    Busy_E    = 1'b0;
    case (state)
      IDLE: if (accept) begin
        Busy_E    = 1'b1;
        state_nxt = special ? DONE : CALC;
      end
      CALC: begin
        Busy_E = !Flush_E;
        if (Flush_E)        state_nxt = IDLE;
        else if (last_step) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath; the result is registered on entry to DONE so the strobe lines up with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op            <= '0;
      neg           <= 1'b0;
      mcand         <= '0;
      acc           <= '0;
      cnt           <= '0;
      Result_E      <= '0;
      rdOut_E       <= '0;
      ResultValid_E <= 1'b0;
    end else begin
      ResultValid_E <= 1'b0;
      if (accept) begin
        op      <= MulDivOp_E;
        neg     <= neg_in;
        rdOut_E <= rd_E;
        mcand   <= mag_b;
        acc     <= {{XLEN{1'b0}}, mag_a};
        cnt     <= '0;
        if (special) begin
          Result_E      <= forced;
          ResultValid_E <= 1'b1;
        end
      end else if (state == CALC && !Flush_E) begin
        acc <= step_nxt;
        cnt <= cnt + CNT_WIDTH'(1);
        if (last_step) begin
          Result_E      <= final_result(op, neg, step_nxt);
          ResultValid_E <= 1'b1;
        end
      end
    end
  end

endmodule
